// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle RV32I control FSM:
// opcodes, state encodings, ALU op codes, PC source codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] AOP_R     = 3'b000;
  localparam logic [2:0] AOP_I     = 3'b001;
  localparam logic [2:0] AOP_LOAD  = 3'b010;
  localparam logic [2:0] AOP_STORE = 3'b011;
  localparam logic [2:0] AOP_BR    = 3'b100;
  localparam logic [2:0] AOP_LUI   = 3'b101;
  localparam logic [2:0] AOP_AUIPC = 3'b110;
  localparam logic [2:0] AOP_JUMP  = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jalr;
    logic jal;
    logic lui;
    logic auipc;
  } cls_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction/data memory request-ready handshake bundle.
// master = control FSM, slave = memory side.
interface multicycle_control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_read;
  logic mem_write;

  modport master (
    output imem_req, dmem_req,
    output mem_read, mem_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req,
    input  mem_read, mem_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm_opcode_class_decoder.sv
// Opcode -> one-hot class, ALU op, ALU-B immediate select, legal.
module opcode_class_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [6:0]          i_op,
  output cls_t                o_cls,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_alu_src,
  output logic                o_legal
);
  logic [2:0] w_aop;

  always_comb begin
    o_cls     = '0;
    w_aop     = AOP_R;
    o_alu_src = 1'b0;
    o_legal   = 1'b1;
    unique case (i_op)
      OP_R: o_cls.r = 1'b1;
      OP_I: begin
        o_cls.i = 1'b1; w_aop = AOP_I; o_alu_src = 1'b1;
      end
      OP_LOAD: begin
        o_cls.load = 1'b1; w_aop = AOP_LOAD; o_alu_src = 1'b1;
      end
      OP_STORE: begin
        o_cls.store = 1'b1; w_aop = AOP_STORE; o_alu_src = 1'b1;
      end
      OP_BRANCH: begin
        o_cls.branch = 1'b1; w_aop = AOP_BR;
      end
      OP_JALR: begin
        o_cls.jalr = 1'b1; w_aop = AOP_JUMP; o_alu_src = 1'b1;
      end
      OP_JAL: begin
        o_cls.jal = 1'b1; w_aop = AOP_JUMP;
      end
      OP_LUI: begin
        o_cls.lui = 1'b1; w_aop = AOP_LUI; o_alu_src = 1'b1;
      end
      OP_AUIPC: begin
        o_cls.auipc = 1'b1; w_aop = AOP_AUIPC; o_alu_src = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

  assign o_alu_op = ALU_OP_W'(w_aop);
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with memory wait timeout and sticky traps.
// Optional perf counters (instret, stall_cycles) under CTRL_PERF_CNT_EN.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                alu_zero,
  multicycle_control_fsm_if.master mem_bus,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_instr,
  output logic                mem_fault,
  output logic [2:0]          state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         instret,
  output logic [31:0]         stall_cycles
`endif
);
  localparam int WAIT_CNT_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_CNT_W-1:0] LP_TMO =
    WAIT_CNT_W'(MEM_TIMEOUT);

  state_t                r_state, w_state_nxt;
  logic [6:0]            r_op_q;
  logic [WAIT_CNT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic                  r_illegal, r_fault;
  logic                  w_set_ill, w_set_flt;
  logic [6:0]            w_dec_op;
  cls_t                  w_cls;
  logic [ALU_OP_W-1:0]   w_aop;
  logic                  w_asrc, w_legal;
  logic                  w_req, w_rdy, w_stall, w_tmo;

  // DECODE judges the live opcode; later states use the latched copy
  assign w_dec_op = (r_state == S_DECODE) ? opcode : r_op_q;

  opcode_class_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .i_op      (w_dec_op),
    .o_cls     (w_cls),
    .o_alu_op  (w_aop),
    .o_alu_src (w_asrc),
    .o_legal   (w_legal)
  );

  assign w_req   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_rdy   = (r_state == S_FETCH) ? mem_bus.imem_ready
                                        : mem_bus.dmem_ready;
  assign w_stall = w_req && !w_rdy;
  assign w_tmo   = w_stall && (MEM_TIMEOUT != 0) &&
                   (r_wait_cnt == LP_TMO);

  always_comb begin
    if (!w_stall)               w_wait_nxt = '0;
    else if (r_wait_cnt != LP_TMO)
      w_wait_nxt = r_wait_cnt + WAIT_CNT_W'(1);
    else                        w_wait_nxt = r_wait_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_q     <= '0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_flt) r_fault   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_set_ill          = 1'b0;
    w_set_flt          = 1'b0;
    mem_bus.imem_req   = 1'b0;
    mem_bus.dmem_req   = 1'b0;
    mem_bus.mem_read   = 1'b0;
    mem_bus.mem_write  = 1'b0;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    pc_src             = PC_SEQ;
    reg_write          = 1'b0;
    mem_to_reg         = 1'b0;
    alu_src            = 1'b0;
    alu_op             = '0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        mem_bus.imem_req = 1'b1;
        if (mem_bus.imem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_tmo) begin
          w_state_nxt = S_TRAP;
          w_set_flt   = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_legal) w_state_nxt = S_EXEC;
        else begin
          w_state_nxt = S_TRAP;
          w_set_ill   = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op  = w_aop;
        alu_src = w_asrc;
        unique case (1'b1)
          w_cls.branch: begin
            pc_write    = alu_zero;
            pc_src      = PC_REL;
            w_state_nxt = S_FETCH;
          end
          w_cls.jal: begin
            pc_write    = 1'b1;
            pc_src      = PC_REL;
            w_state_nxt = S_WB;
          end
          w_cls.jalr: begin
            pc_write    = 1'b1;
            pc_src      = PC_REG;
            w_state_nxt = S_WB;
          end
          w_cls.load, w_cls.store: w_state_nxt = S_MEM;
          w_cls.r, w_cls.i, w_cls.lui, w_cls.auipc:
            w_state_nxt = S_WB;
          default: w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        alu_op            = w_aop;
        alu_src           = w_asrc;
        mem_bus.dmem_req  = 1'b1;
        mem_bus.mem_read  = w_cls.load;
        mem_bus.mem_write = w_cls.store;
        if (mem_bus.dmem_ready)
          w_state_nxt = w_cls.load ? S_WB : S_FETCH;
        else if (w_tmo) begin
          w_state_nxt = S_TRAP;
          w_set_flt   = 1'b1;
        end
      end
      S_WB: begin
        alu_op      = w_aop;
        alu_src     = w_asrc;
        reg_write   = 1'b1;
        mem_to_reg  = w_cls.load;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: w_state_nxt = S_TRAP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign illegal_instr = r_illegal;
  assign mem_fault     = r_fault;
  assign state_o       = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_instret, r_stall;
  logic        w_retire;

  assign w_retire = (w_state_nxt == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) ||
                     (r_state == S_WB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
      r_stall   <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 32'd1;
      if (w_stall)  r_stall   <= r_stall + 32'd1;
    end
  end

  assign instret      = r_instret;
  assign stall_cycles = r_stall;
`endif
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle RV32I control unit. It sequences FETCH/DECODE/EXEC/MEM/WB per instruction and issues per-state control strobes to the shared datapath. It handshakes with instruction and data memories through req/ready pairs, with a bounded wait timeout. Illegal opcodes and memory timeouts put it in a sticky trap state. It sits between the instruction register and the datapath muxes, register file and memory ports.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before trapping; 0 = wait forever
ALU_OP_W, 3, width of alu_op output; must be >= 3
WAIT_CNT_W, $clog2(MEM_TIMEOUT+1) (min 1), derived width of the wait counter; localparam, not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  7  instr[6:0] from IR; valid from the cycle after ir_write
alu_zero  input  1  ALU zero flag; sampled in EXEC
imem_ready  input  1  instruction memory has data this cycle
dmem_ready  input  1  data memory access completes this cycle
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
mem_read  output  1  load access (qualifies dmem_req)
mem_write  output  1  store access (qualifies dmem_req)
ir_write  output  1  latch instruction and old PC
pc_write  output  1  update PC this cycle
pc_src  output  2  00 PC+4, 01 old_PC+imm (branch/JAL), 10 rs1+imm (JALR)
reg_write  output  1  register file write enable
mem_to_reg  output  1  WB selects memory data
alu_src  output  1  ALU B operand = immediate
alu_op  output  ALU_OP_W  000 R, 001 I-arith, 010 load, 011 store, 100 branch, 101 LUI, 110 AUIPC, 111 JAL/JALR
illegal_instr  output  1  sticky: unknown opcode decoded
mem_fault  output  1  sticky: memory wait timeout
state_o  output  3  current state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Reset: state IDLE, op_q=0, wait counter 0, illegal_instr=0, mem_fault=0. All strobes 0 in IDLE and TRAP.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH: imem_req=1. When imem_ready=1, assert ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise stay in FETCH.
- DECODE: latch op_q<=opcode. Unknown opcode -> TRAP and set illegal_instr. Otherwise -> EXEC.
- EXEC: alu_op from op_q. alu_src=1 for I-arith, load, store, JALR, LUI, AUIPC.
  - Branch: pc_write=alu_zero, pc_src=01, then -> FETCH.
  - JAL: pc_write=1, pc_src=01. JALR: pc_write=1, pc_src=10. Both -> WB.
  - Load/store -> MEM. All others -> WB.
- MEM: dmem_req=1, plus mem_read (load) or mem_write (store). alu_op and alu_src hold their EXEC values. On dmem_ready: load -> WB, store -> FETCH. Otherwise stay in MEM.
- WB: reg_write=1. mem_to_reg=1 for load only. alu_op and alu_src hold their EXEC values. -> FETCH.
- Zero-wait latencies (instruction start to next FETCH): branch 3, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle req=1 and ready=0, saturating at MEM_TIMEOUT.
  - If counter==MEM_TIMEOUT and ready=0 (MEM_TIMEOUT>0): go to TRAP, set mem_fault.
  - If ready=1 in the same cycle the limit is hit, ready wins and there is no trap.
- TRAP is absorbing; only rst exits. illegal_instr and mem_fault stay set until reset.
- Reset asserted mid-instruction: all state, counter and flags clear asynchronously and every strobe drops in that same cycle; no partial writeback.
- Ready inputs are ignored in states that do not request them.

Optional Feature:
CTRL_PERF_CNT_EN. When defined, add output instret[31:0] and output stall_cycles[31:0].
- instret increments on every transition into FETCH from EXEC, MEM or WB.
- stall_cycles increments on every req=1, ready=0 cycle.
- Both wrap at 2^32 and reset to 0.

When undefined, neither port nor counter exists and the rest of the behaviour is identical.

Decomposition:
- Package ctrl_pkg holds: opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111); the state encodings; the ALU_OP codes; the pc_src codes.
- One combinational sub-module, opcode_class_decoder: op_q -> one-hot instruction class, alu_op, alu_src, legal flag.
- The FSM, wait counter and sticky flags stay in the top module.

Test Plan:
- Reset, then opcode=0110011, imem_ready=1 and dmem_ready=1 held. Required: state sequence 0,1,2,3,5,1; reg_write=1 only in WB; alu_op=000.
- Load 0000011, dmem_ready low for 3 MEM cycles then high. Required: MEM lasts 4 cycles with dmem_req=mem_read=1; WB has mem_to_reg=1; total 8 cycles FETCH to FETCH.
- Branch 1100011, first pass alu_zero=1, second pass alu_zero=0. Required: EXEC pc_write=1 with pc_src=01 on the first pass; pc_write=0 on the second; neither pass visits WB.
- opcode=1111111. Required: DECODE -> TRAP; illegal_instr=1 stays high over 20 cycles; all strobes 0; rst clears it.
- MEM_TIMEOUT=4 with imem_ready held 0. Required: TRAP entered on the 5th FETCH cycle with mem_fault=1. Rerun with imem_ready=1 on that 5th cycle: no trap, -> DECODE.
- Assert rst during MEM of a store with dmem_req=1. Required: dmem_req and mem_write drop in the same cycle; state_o=0.
